i4004_instr_decoder: RTL and testbench
======================================

// Module: i4004_instr_decoder
// PURPOSE
// - Inverse of the opcode_pkg encoding: rebuilds instruction bytes from the nibble-serial fetch stream and emits opcode_pkg::opcode_t.
// - Fetch stream order: M1 OPR nibble, then M2 OPA nibble.
// - Gathers the second word of two-word instructions.
// - Sits between the fetch/bus sequencer and the execute FSM; presents one decoded instruction at a time over a valid/ready handshake.
// PARAMETERS
// - CNT_W  16  width of the decoded-instruction counter dec_count (wraps modulo 2**CNT_W)
// PORTS
// - clk         in   1      single clock; all state updates on rising edge
// - rst         in   1      reset, synchronous, active-high
// - flush       in   1      discard partial/held instruction (taken branch, jump)
// - nib_valid   in   1      nib_data holds a fetched nibble
// - nib_ready   out  1      decoder accepts nibble this cycle
// - nib_data    in   4      fetched nibble (OPR, OPA, then 2nd-word hi, lo)
// - dec_valid   out  1      decoded instruction available
// - dec_ready   in   1      execute stage consumes instruction
// - dec_op      out  8      opcode_pkg::opcode_t
// - dec_opa     out  4      raw OPA nibble (register/pair/condition/data field)
// - dec_imm     out  8      second word {hi,lo}; 8'h00 for one-word instructions
// - dec_two     out  1      instruction was two-word
// - dec_illegal out  1      undefined encoding (see CONFIGURATION)
// - dec_count   out  CNT_W  number of completed dec handshakes
// BEHAVIOUR
// - Reset (rst=1 at an edge)
//   - All outputs 0, i.e. dec_op=NOP and dec_count=0.
//   - State=S_OPR.
//   - Overrides flush and all handshakes.
// - States: S_OPR -> S_OPA -> (two-word ? S_W2H -> S_W2L : -) -> S_HOLD -> S_OPR.
//   - Advance only on a nibble transfer (nib_valid & nib_ready).
// - nib_ready = (state != S_HOLD). Combinational from state only.
// - dec_valid = (state == S_HOLD). Outputs are registered.
//   - dec_valid rises the cycle after the last nibble transfer.
//   - Outputs stay stable while dec_valid & !dec_ready.
// - S_HOLD & dec_ready: handshake completes.
//   - Next state is S_OPR and dec_count increments.
//   - No nibble is taken in that cycle.
//   - Peak throughput: 3 cycles per one-word instruction, 5 per two-word.
// - Mapping:
//   - OPR 1,4..D: dec_op = {OPR,4'h0}.
//   - OPR 2,3: dec_op = {OPR,3'b000,OPA[0]} (FIM/SRC, FIN/JIN).
//   - OPR E: dec_op = {4'hE,OPA}.
//   - OPR F, OPA<=D: dec_op = {4'hF,OPA}.
//   - OPR 0, OPA=0: NOP.
// - Two-word instructions: JCN, JUN, JMS, ISZ, and FIM (OPR=2 & OPA[0]=0).
//   - dec_imm is captured hi then lo.
// - Illegal encodings: OPR 0 with OPA!=0; FE; FF. Handling is per CONFIGURATION.
//   - Never two-word.
// - flush=1: next state is S_OPR and dec_valid drops.
//   - Any nibble offered that cycle is discarded.
//   - A held instruction is dropped uncounted, even if dec_ready=1.
//   - dec_count is unchanged.
// - Mid-operation rst behaves the same as flush, and additionally clears dec_count.
// - Back-pressure: dec_ready may stay low indefinitely. nib_ready stays 0 for that time.
// CONFIGURATION
// - ILLEGAL_TRAP_EN defined:
//   - On an illegal encoding, dec_op=NOP and dec_illegal=1 for that held instruction.
//   - dec_opa still carries the raw OPA.
// - ILLEGAL_TRAP_EN undefined:
//   - Illegal encodings decode silently as NOP.
//   - dec_illegal is tied 0.
// TESTING
// - Nibbles D,5 -> dec_op=LDM, dec_opa=5, dec_two=0, dec_imm=00.
//   - dec_valid 1 cycle after the 2nd nibble.
//   - dec_count 0->1 on ready.
// - Nibbles 4,1,2,3 -> dec_op=JUN, dec_opa=1, dec_imm=8'h23, dec_two=1.
// - Nibbles 2,4,A,5 -> FIM, dec_imm=8'hA5.
// - Nibbles 2,5 -> SRC with one word.
// - Nibbles 3,1 -> JIN.
// - Nibbles F,2 with dec_ready=0 for 10 cycles -> IAC held.
//   - Outputs are stable and nib_ready=0 throughout.
//   - Offered nibbles are not consumed.
// - Nibbles 1,C,7, then flush, then F,1 -> JCN dropped and CLC decoded.
//   - dec_count increments once.
// - Nibbles F,E:
//   - ILLEGAL_TRAP_EN defined -> NOP with dec_illegal=1.
//   - ILLEGAL_TRAP_EN undefined -> NOP with dec_illegal=0.
// - CNT_W=2, 5 instructions completed -> dec_count=1 (wraps).
// - rst asserted in S_W2H -> next cycle all outputs 0, S_OPR, nib_ready=1.

Source files
------------

// File: rtl/i4004_instr_decoder.sv
// Rebuilds 4004 instruction bytes from the nibble-serial fetch stream and
// hands one decoded instruction at a time to execute. Optional: ILLEGAL_TRAP_EN.
module i4004_instr_decoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             nib_valid,
   output logic             nib_ready,
   input  logic [3:0]       nib_data,
   output logic             dec_valid,
   input  logic             dec_ready,
   output logic [7:0]       dec_op,
   output logic [3:0]       dec_opa,
   output logic [7:0]       dec_imm,
   output logic             dec_two,
   output logic             dec_illegal,
   output logic [CNT_W-1:0] dec_count
);

   typedef enum logic [2:0] {
      S_OPR  = 3'd0,
      S_OPA  = 3'd1,
      S_W2H  = 3'd2,
      S_W2L  = 3'd3,
      S_HOLD = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] opr_q;
   logic       xfer;
   logic       done;
   logic [7:0] op_comb;
   logic       two_comb;

   assign nib_ready = (state != S_HOLD);
   assign dec_valid = (state == S_HOLD);
   assign xfer      = nib_valid & nib_ready;
   assign done      = dec_valid & dec_ready;

   // Decode uses the latched OPR and the OPA nibble arriving this cycle.
   always_comb begin
      op_comb = 8'h00;
      case (opr_q)
         4'h0:       op_comb = 8'h00;
         4'h2, 4'h3: op_comb = {opr_q, 3'b000, nib_data[0]};
         4'hE:       op_comb = {4'hE, nib_data};
         4'hF:       if (nib_data <= 4'hD) op_comb = {4'hF, nib_data};
         default:    op_comb = {opr_q, 4'h0};
      endcase
      two_comb = (opr_q == 4'h1) || (opr_q == 4'h4) || (opr_q == 4'h5) ||
                 (opr_q == 4'h7) || ((opr_q == 4'h2) && !nib_data[0]);
   end

`ifdef ILLEGAL_TRAP_EN
   logic ill_comb;
   assign ill_comb = ((opr_q == 4'h0) && (nib_data != 4'h0)) ||
                     ((opr_q == 4'hF) && (nib_data >= 4'hE));
`else
   assign dec_illegal = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= S_OPR;
      else     state <= state_nxt;
   end

   // Flush wins over both the nibble and the result handshakes.
   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_OPR;
      end else begin
         case (state)
            S_OPR:   if (xfer) state_nxt = S_OPA;
            S_OPA:   if (xfer) state_nxt = two_comb ? S_W2H : S_HOLD;
            S_W2H:   if (xfer) state_nxt = S_W2L;
            S_W2L:   if (xfer) state_nxt = S_HOLD;
            S_HOLD:  if (dec_ready) state_nxt = S_OPR;
            default: state_nxt = S_OPR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opr_q     <= 4'h0;
         dec_op    <= 8'h00;
         dec_opa   <= 4'h0;
         dec_imm   <= 8'h00;
         dec_two   <= 1'b0;
         dec_count <= '0;
`ifdef ILLEGAL_TRAP_EN
         dec_illegal <= 1'b0;
`endif
      end else if (!flush) begin
         if (done) dec_count <= dec_count + CNT_ONE;
         if (xfer) begin
            case (state)
               S_OPR: opr_q <= nib_data;
               S_OPA: begin
                  dec_op  <= op_comb;
                  dec_opa <= nib_data;
                  dec_two <= two_comb;
                  dec_imm <= 8'h00;
`ifdef ILLEGAL_TRAP_EN
                  dec_illegal <= ill_comb;
`endif
               end
               S_W2H:   dec_imm[7:4] <= nib_data;
               S_W2L:   dec_imm[3:0] <= nib_data;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i4004_instr_decoder.sv
// Bench for i4004_instr_decoder: known-instruction table, corner sequences,
// then random traffic against a nibble-queue reference model.
module tb_i4004_instr_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, flush, nib_valid, dec_ready;
   logic [3:0] nib_data;

   logic        nib_ready, dec_valid, dec_two, dec_illegal;
   logic [7:0]  dec_op, dec_imm;
   logic [3:0]  dec_opa;
   logic [15:0] dec_count;

   logic       nib_ready2, dec_valid2, dec_two2, dec_illegal2;
   logic [7:0] dec_op2, dec_imm2;
   logic [3:0] dec_opa2;
   logic [1:0] dec_count2;

   i4004_instr_decoder #(.CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .nib_valid(nib_valid), .nib_ready(nib_ready), .nib_data(nib_data),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_op(dec_op), .dec_opa(dec_opa), .dec_imm(dec_imm),
      .dec_two(dec_two), .dec_illegal(dec_illegal), .dec_count(dec_count)
   );

   i4004_instr_decoder #(.CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .flush(flush),
      .nib_valid(nib_valid), .nib_ready(nib_ready2), .nib_data(nib_data),
      .dec_valid(dec_valid2), .dec_ready(dec_ready),
      .dec_op(dec_op2), .dec_opa(dec_opa2), .dec_imm(dec_imm2),
      .dec_two(dec_two2), .dec_illegal(dec_illegal2), .dec_count(dec_count2)
   );

`ifdef ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   int vectors = 0;
   int miscompares = 0;

   // Reference model: nibbles gathered so far plus the instruction on offer.
   logic [3:0]  q[$];
   bit          held, just_reset;
   logic [7:0]  e_op, e_imm;
   logic [3:0]  e_opa;
   bit          e_two, e_ill;
   int unsigned e_cnt;

   typedef struct {
      string       name;
      logic [15:0] nibs;
      int          n;
      logic [7:0]  op;
      logic [3:0]  opa;
      logic [7:0]  imm;
      bit          two;
      bit          ill;
   } vec_t;
   vec_t tbl[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void refDecode(input logic [3:0] opr, input logic [3:0] opa,
                                     output logic [7:0] op, output bit two, output bit ill);
      int o = int'(opr);
      int a = int'(opa);
      ill = (o == 0 && a != 0) || (o == 15 && a >= 14);
      two = (o == 1 || o == 4 || o == 5 || o == 7 || (o == 2 && a % 2 == 0));
      if (ill || o == 0)         op = 8'h00;
      else if (o == 2 || o == 3) op = 8'(o * 16 + a % 2);
      else if (o >= 14)          op = 8'(o * 16 + a);
      else                       op = 8'(o * 16);
   endfunction

   task automatic modelStep();
      logic [7:0] op;
      bit two, ill;
      just_reset = 1'b0;
      if (rst) begin
         q.delete();
         held = 1'b0; just_reset = 1'b1;
         e_op = 8'h00; e_opa = 4'h0; e_imm = 8'h00; e_two = 1'b0; e_ill = 1'b0;
         e_cnt = 0;
      end else if (flush) begin
         q.delete();
         held = 1'b0;
      end else if (held) begin
         if (dec_ready) begin
            held = 1'b0;
            e_cnt++;
         end
      end else if (nib_valid) begin
         q.push_back(nib_data);
         if (q.size() >= 2) begin
            refDecode(q[0], q[1], op, two, ill);
            if (q.size() == (two ? 4 : 2)) begin
               held  = 1'b1;
               e_op  = op;
               e_opa = q[1];
               e_imm = two ? {q[2], q[3]} : 8'h00;
               e_two = two;
               e_ill = TRAP && ill;
               q.delete();
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      checkOutput("nib_ready", 32'(nib_ready), 32'(!held));
      checkOutput("dec_valid", 32'(dec_valid), 32'(held));
      checkOutput("dec_count", 32'(dec_count), e_cnt % 65536);
      checkOutput("dec_count_w2", 32'(dec_count2), e_cnt % 4);
      if (held || just_reset) begin
         checkOutput("dec_op", 32'(dec_op), 32'(e_op));
         checkOutput("dec_opa", 32'(dec_opa), 32'(e_opa));
         checkOutput("dec_imm", 32'(dec_imm), 32'(e_imm));
         checkOutput("dec_two", 32'(dec_two), 32'(e_two));
         checkOutput("dec_illegal", 32'(dec_illegal), 32'(e_ill));
      end
   endtask

   task automatic applyStimulus(input bit r, input bit f, input bit v,
                                input logic [3:0] d, input bit rdy);
      rst = r; flush = f; nib_valid = v; nib_data = d; dec_ready = rdy;
      tick();
   endtask

   task automatic addVec(input string name, input logic [15:0] nibs, input int n,
                         input logic [7:0] op, input logic [3:0] opa, input logic [7:0] imm,
                         input bit two, input bit ill);
      vec_t v;
      v.name = name; v.nibs = nibs; v.n = n; v.op = op; v.opa = opa;
      v.imm = imm; v.two = two; v.ill = ill;
      tbl.push_back(v);
   endtask

   task automatic feedNibbles(input logic [15:0] nibs, input int n);
      logic [15:0] w;
      w = nibs;
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, w[15:12], 1'b0);
         w = w << 4;
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; nib_valid = 1'b0; nib_data = 4'h0; dec_ready = 1'b0;
      held = 1'b0; just_reset = 1'b0; e_cnt = 0;

      addVec("LDM", 16'hD500, 2, 8'hD0, 4'h5, 8'h00, 1'b0, 1'b0);
      addVec("JUN", 16'h4123, 4, 8'h40, 4'h1, 8'h23, 1'b1, 1'b0);
      addVec("FIM", 16'h24A5, 4, 8'h20, 4'h4, 8'hA5, 1'b1, 1'b0);
      addVec("SRC", 16'h2500, 2, 8'h21, 4'h5, 8'h00, 1'b0, 1'b0);
      addVec("JIN", 16'h3100, 2, 8'h31, 4'h1, 8'h00, 1'b0, 1'b0);
      addVec("IAC", 16'hF200, 2, 8'hF2, 4'h2, 8'h00, 1'b0, 1'b0);
      addVec("FE",  16'hFE00, 2, 8'h00, 4'hE, 8'h00, 1'b0, TRAP);
      addVec("NOP", 16'h0000, 2, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0);
      addVec("WRx", 16'hE900, 2, 8'hE9, 4'h9, 8'h00, 1'b0, 1'b0);
      addVec("JCN", 16'h1C34, 4, 8'h10, 4'hC, 8'h34, 1'b1, 1'b0);
      addVec("ISZ", 16'h72FF, 4, 8'h70, 4'h2, 8'hFF, 1'b1, 1'b0);
      addVec("JMS", 16'h5012, 4, 8'h50, 4'h0, 8'h12, 1'b1, 1'b0);
      addVec("OP03", 16'h0300, 2, 8'h00, 4'h3, 8'h00, 1'b0, TRAP);
      addVec("FD",  16'hFD00, 2, 8'hFD, 4'hD, 8'h00, 1'b0, 1'b0);
      addVec("FF",  16'hFF00, 2, 8'h00, 4'hF, 8'h00, 1'b0, TRAP);

      applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'h4, 1'b1);

      for (int i = 0; i < tbl.size(); i++) begin
         feedNibbles(tbl[i].nibs, tbl[i].n);
         checkOutput({tbl[i].name, ".valid"}, 32'(dec_valid), 32'd1);
         checkOutput({tbl[i].name, ".op"}, 32'(dec_op), 32'(tbl[i].op));
         checkOutput({tbl[i].name, ".opa"}, 32'(dec_opa), 32'(tbl[i].opa));
         checkOutput({tbl[i].name, ".imm"}, 32'(dec_imm), 32'(tbl[i].imm));
         checkOutput({tbl[i].name, ".two"}, 32'(dec_two), 32'(tbl[i].two));
         checkOutput({tbl[i].name, ".ill"}, 32'(dec_illegal), 32'(tbl[i].ill));
         applyStimulus(1'b0, 1'b0, 1'b1, 4'h6, 1'b1);
         checkOutput({tbl[i].name, ".count"}, 32'(dec_count), 32'(i + 1));
      end

      // Back-pressure: IAC held for 10 cycles while nibbles are offered.
      feedNibbles(16'hF200, 2);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b0, 1'b0, 1'b1, 4'(i), 1'b0);
      checkOutput("bp.op", 32'(dec_op), 32'hF2);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);

      // JCN partially fetched, flushed, then CLC decoded.
      feedNibbles(16'h1C70, 3);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'h9, 1'b1);
      feedNibbles(16'hF100, 2);
      checkOutput("flush.op", 32'(dec_op), 32'hF1);
      checkOutput("flush.two", 32'(dec_two), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);

      // Flush while holding with dec_ready high drops the instruction.
      feedNibbles(16'hD300, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);

      // Reset while waiting for the high immediate nibble.
      feedNibbles(16'h4100, 2);
      applyStimulus(1'b1, 1'b0, 1'b1, 4'h2, 1'b1);
      checkOutput("rstw2h.nib_ready", 32'(nib_ready), 32'd1);
      checkOutput("rstw2h.count", 32'(dec_count), 32'd0);

      // Counter wrap on the 2-bit instance.
      for (int i = 0; i < 5; i++) begin
         feedNibbles(16'hD500, 2);
         applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
      end
      checkOutput("wrap5.count_w2", 32'(dec_count2), 32'd1);
      checkOutput("wrap5.count", 32'(dec_count), 32'd5);

      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
                       $urandom_range(0, 3) != 0, 4'($urandom), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
